// File: rtl/instr_prefetch_buffer.sv
// Fetch front end with a DEPTH-entry prefetch queue.
// Sequential reads are issued over a request/valid handshake. Returned words
// are queued together with their PCs and handed to decode over valid/ready.
// A redirect flushes the queue. A response that is still in flight when the
// redirect arrives is allowed to finish and is then discarded.
//
// state   | meaning
// IDLE    | no request outstanding (queue full, or just out of reset)
// REQ     | read of req_addr outstanding; accepted data is queued
// DISCARD | read outstanding whose data is stale after a redirect
module instr_prefetch_buffer #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_en,
  input  logic [XLEN-1:0]            redirect_addr,
  input  logic [31:0]                instruction_fetch,
  input  logic                       instruc_mem_valid,
  output logic                       instruction_mem_request,
  output logic                       instruction_mem_we_re,
  output logic [3:0]                 instruc_mask_singal,
  output logic [XLEN-1:0]            pc_address,
  output logic [31:0]                instr_out,
  output logic [XLEN-1:0]            instr_pc_out,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH+1)-1:0] buf_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_addr;
  logic [31:0]     q_instr [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic            pop;
  logic            push;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] fetch_pc_inc;
  logic [CW-1:0]   count_after_push;

  assign pop              = (count != '0) && instr_ready;
  assign push             = (state == REQ) && instruc_mem_valid && !redirect_en;
  assign redirect_pc      = redirect_addr & ~XLEN'(3);
  assign fetch_pc_inc     = fetch_pc + XLEN'(4);
  // Occupancy after an accepted response, counting a simultaneous pop.
  assign count_after_push = count + CW'(1) - (pop ? CW'(1) : CW'(0));

  // Queue storage, pointers and occupancy; redirect flush beats push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (redirect_en) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_instr[wr_ptr] <= instruction_fetch;
        q_pc[wr_ptr]    <= req_addr;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Fetch sequencing: a request is only opened when a queue slot is free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else if (redirect_en) begin
      fetch_pc <= redirect_pc;
      case (state)
        IDLE: begin
          state    <= REQ;
          req_addr <= redirect_pc;
        end
        REQ: begin
          if (instruc_mem_valid) begin
            req_addr <= redirect_pc;
          end else begin
            state <= DISCARD;
          end
        end
        default: state <= DISCARD;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (count < CW'(DEPTH)) begin
            state    <= REQ;
            req_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (instruc_mem_valid) begin
            fetch_pc <= fetch_pc_inc;
            if (count_after_push < CW'(DEPTH)) begin
              req_addr <= fetch_pc_inc;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          if (instruc_mem_valid) begin
            state    <= REQ;
            req_addr <= fetch_pc;
          end
        end
      endcase
    end
  end

  assign instruction_mem_request = (state != IDLE);
  assign instruction_mem_we_re   = 1'b0;
  assign instruc_mask_singal     = 4'hF;
  assign pc_address              = req_addr;
  assign instr_out               = q_instr[rd_ptr];
  assign instr_pc_out            = q_pc[rd_ptr];
  assign instr_valid             = (count != '0);
  assign buf_count               = count;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Randomized bench for instr_prefetch_buffer.
// A queue-based reference model predicts request/address and queue contents.
// A memory model with random latency returns 0x13 + address.
module tb_instr_prefetch_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic [31:0] instruction_fetch = '0;
  logic        instruc_mem_valid = 1'b0;
  logic        instr_ready = 1'b0;
  logic        instruction_mem_request;
  logic        instruction_mem_we_re;
  logic [3:0]  instruc_mask_singal;
  logic [31:0] pc_address;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
  logic        instr_valid;
  logic [2:0]  buf_count;

  instr_prefetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .redirect_en             (redirect_en),
    .redirect_addr           (redirect_addr),
    .instruction_fetch       (instruction_fetch),
    .instruc_mem_valid       (instruc_mem_valid),
    .instruction_mem_request (instruction_mem_request),
    .instruction_mem_we_re   (instruction_mem_we_re),
    .instruc_mask_singal     (instruc_mask_singal),
    .pc_address              (pc_address),
    .instr_out               (instr_out),
    .instr_pc_out            (instr_pc_out),
    .instr_valid             (instr_valid),
    .instr_ready             (instr_ready),
    .buf_count               (buf_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: request open flag, stale-data flag, next PC, queue.
  bit          m_req, m_drop, m_clean;
  logic [31:0] m_fpc, m_raddr;
  logic [63:0] mq[$];

  // Memory model state.
  bit  mem_busy;
  int  mem_lat;
  int  ready_pct, redir_pct;
  bit  zero_wait;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req   = 0;
    m_drop  = 0;
    m_clean = 1;
    m_fpc   = RPC;
    m_raddr = RPC;
    mq.delete();
    mem_busy = 0;
    mem_lat  = 0;
  endtask

  task automatic check_outputs();
    chk("request", 64'(instruction_mem_request), 64'(m_req));
    if (m_req) chk("pc_address", 64'(pc_address), 64'(m_raddr));
    chk("instr_valid", 64'(instr_valid), 64'(mq.size() != 0));
    chk("buf_count", 64'(buf_count), 64'(mq.size()));
    chk("we_re", 64'(instruction_mem_we_re), 64'(0));
    chk("mask", 64'(instruc_mask_singal), 64'(4'hF));
    if (mq.size() != 0) begin
      chk("instr_out", 64'(instr_out), 64'(mq[0][63:32]));
      chk("instr_pc_out", 64'(instr_pc_out), 64'(mq[0][31:0]));
    end else if (m_clean) begin
      chk("instr_out_rst", 64'(instr_out), 64'(0));
      chk("instr_pc_rst", 64'(instr_pc_out), 64'(0));
    end
  endtask

  task automatic check_in_reset(input string tag);
    chk({tag, "_request"}, 64'(instruction_mem_request), 64'(0));
    chk({tag, "_valid"}, 64'(instr_valid), 64'(0));
    chk({tag, "_count"}, 64'(buf_count), 64'(0));
  endtask

  // Called just after a falling edge: picks inputs for the coming rising
  // edge, drives them and advances the model across that edge.
  task automatic drive_and_model();
    bit          rdy, rdo, vld, pop;
    int          sz0;
    logic [31:0] ra, data;
    rdy = ($urandom_range(99) < ready_pct);
    rdo = ($urandom_range(99) < redir_pct);
    ra  = $urandom_range(1) ? $urandom : (32'h200 + 32'($urandom_range(15)));
    if (instruction_mem_request && !mem_busy) begin
      mem_busy = 1;
      mem_lat  = zero_wait ? 0 : $urandom_range(3);
    end
    vld = mem_busy && (mem_lat == 0);
    if (mem_busy && mem_lat != 0) mem_lat--;
    data = 32'h13 + pc_address;

    instr_ready       = rdy;
    redirect_en       = rdo;
    redirect_addr     = ra;
    instruc_mem_valid = vld;
    instruction_fetch = vld ? data : $urandom;

    sz0 = mq.size();
    pop = (sz0 != 0) && rdy;
    if (rdo) begin
      mq.delete();
      m_fpc = ra & ~32'h3;
      if (!m_req) begin
        m_req   = 1;
        m_raddr = m_fpc;
      end else if (!m_drop) begin
        if (vld) m_raddr = m_fpc;
        else     m_drop  = 1;
      end
    end else begin
      if (pop) void'(mq.pop_front());
      if (!m_req) begin
        if (sz0 < DEPTH) begin
          m_req   = 1;
          m_raddr = m_fpc;
        end
      end else if (vld) begin
        if (m_drop) begin
          m_drop  = 0;
          m_raddr = m_fpc;
        end else begin
          mq.push_back({32'h13 + m_raddr, m_raddr});
          m_clean = 0;
          m_fpc   = m_fpc + 32'd4;
          if (mq.size() < DEPTH) m_raddr = m_fpc;
          else                   m_req   = 0;
        end
      end
    end
    if (vld) mem_busy = 0;
  endtask

  initial begin
    ready_pct = 100;
    redir_pct = 0;
    zero_wait = 1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_in_reset("reset");
    end
    rst = 1'b1;
    drive_and_model();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      check_outputs();
      case ((cyc / 250) % 4)
        0: ready_pct = 100;
        1: ready_pct = 0;
        2: ready_pct = 60;
        default: ready_pct = 25;
      endcase
      zero_wait = ((cyc / 250) % 3) == 0;
      redir_pct = (cyc < 100) ? 0 : ((ready_pct == 0) ? 2 : 5);
      if (cyc == 1500 || cyc == 2400) begin
        #2 rst = 1'b0;
        redirect_en       = 1'b0;
        instruc_mem_valid = 1'b0;
        #1 check_in_reset("async_rst");
        @(negedge clk);
        check_in_reset("held_rst");
        model_reset();
        rst = 1'b1;
      end
      drive_and_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
